// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage definitions: next-address select encoding and the
// alignment-mask helper used to clear the low bits of loaded targets.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_HOLD,
    SEL_RAS,
    SEL_PRED,
    SEL_SEQ
  } next_sel_e;

  // Mask with the low log2(instr_bytes) bits cleared; callers truncate to ADDR_W.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: top pointer, saturating count, and
// push / pop / replace-in-place / clear handling.
module ras_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign top_data = mem_q[top_q];

  always_comb begin
    top_d     = top_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = top_q;
    if (clear) begin
      top_d   = '0;
      count_d = '0;
    end else if (push && pop && !empty) begin
      // Return immediately followed by a call: swap the top entry in place.
      mem_we = 1'b1;
    end else if (push) begin
      top_d     = top_q + PTR_W'(1);
      mem_we    = 1'b1;
      mem_waddr = top_d;
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC unit: fetch address register, next-address priority mux,
// target alignment and call/return prediction through the RAS.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        RAS_DEPTH    = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  output logic [ADDR_W-1:0]          InstrAddr,
  output logic [ADDR_W-1:0]          PC,
  input  logic                       FlushPipeandPC,
  input  logic [ADDR_W-1:0]          JmpAddr,
  input  logic                       PCStall,
  input  logic                       PCSource,
  input  logic [ADDR_W-1:0]          Predict,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic                       RasClear,
  output logic                       RasEmpty,
  output logic                       RasFull,
  output logic [$clog2(RAS_DEPTH):0] RasCount
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INSTR_BYTES));
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_en;
  next_sel_e         next_sel;

  assign InstrAddr = instr_addr_q;
  assign PC        = instr_addr_q + STEP;

  // Flush and stall freeze the RAS so a squashed fetch leaves no trace.
  assign ras_en = !FlushPipeandPC && !PCStall;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (Call && ras_en),
    .pop       (Ret && ras_en),
    .clear     (RasClear),
    .push_data (PC),
    .top_data  (ras_top),
    .empty     (RasEmpty),
    .full      (RasFull),
    .count     (RasCount)
  );

  always_comb begin
    next_sel = SEL_SEQ;
    if (FlushPipeandPC)         next_sel = SEL_FLUSH;
    else if (PCStall)           next_sel = SEL_HOLD;
    else if (Ret && !RasEmpty)  next_sel = SEL_RAS;
    else if (PCSource)          next_sel = SEL_PRED;
  end

  always_comb begin
    instr_addr_d = PC;
    case (next_sel)
      SEL_FLUSH: instr_addr_d = JmpAddr & ALIGN_MASK;
      SEL_HOLD:  instr_addr_d = instr_addr_q;
      SEL_RAS:   instr_addr_d = ras_top & ALIGN_MASK;
      SEL_PRED:  instr_addr_d = Predict & ALIGN_MASK;
      SEL_SEQ:   instr_addr_d = PC;
      default:   instr_addr_d = PC;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) instr_addr_q <= RESET_VECTOR;
    else        instr_addr_q <= instr_addr_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit/4-entry-RAS instance and a
// 16-bit/2-byte-instruction instance, checked against hand-computed addresses.
module tb_pc_sequencer;

  logic Clk;
  logic Rst_n;

  // Instance A: ADDR_W=32, INSTR_BYTES=4, RAS_DEPTH=4
  logic [31:0] a_instr, a_pc, a_jmp, a_pred;
  logic        a_flush, a_stall, a_src, a_call, a_ret, a_clr;
  logic        a_empty, a_full;
  logic [2:0]  a_cnt;

  // Instance B: ADDR_W=16, INSTR_BYTES=2, RAS_DEPTH=8
  logic [15:0] b_instr, b_pc, b_jmp, b_pred;
  logic        b_flush, b_stall, b_src, b_call, b_ret, b_clr;
  logic        b_empty, b_full;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .ADDR_W(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)
  ) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .InstrAddr(a_instr), .PC(a_pc),
    .FlushPipeandPC(a_flush), .JmpAddr(a_jmp), .PCStall(a_stall),
    .PCSource(a_src), .Predict(a_pred), .Call(a_call), .Ret(a_ret),
    .RasClear(a_clr), .RasEmpty(a_empty), .RasFull(a_full), .RasCount(a_cnt)
  );

  pc_sequencer #(
    .ADDR_W(16), .INSTR_BYTES(2), .RESET_VECTOR(16'h0), .RAS_DEPTH(8)
  ) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .InstrAddr(b_instr), .PC(b_pc),
    .FlushPipeandPC(b_flush), .JmpAddr(b_jmp), .PCStall(b_stall),
    .PCSource(b_src), .Predict(b_pred), .Call(b_call), .Ret(b_ret),
    .RasClear(b_clr), .RasEmpty(b_empty), .RasFull(b_full), .RasCount(b_cnt)
  );

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic a_idle();
    a_flush = 1'b0; a_jmp = '0; a_stall = 1'b0; a_src = 1'b0;
    a_pred = '0; a_call = 1'b0; a_ret = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_idle();
    b_flush = 1'b0; b_jmp = '0; b_stall = 1'b0; b_src = 1'b0;
    b_pred = '0; b_call = 1'b0; b_ret = 1'b0; b_clr = 1'b0;
  endtask

  task automatic a_flush_to(input logic [31:0] target);
    a_idle();
    a_flush = 1'b1; a_jmp = target;
    tick();
    a_idle();
  endtask

  initial begin
    a_idle();
    b_idle();
    Rst_n = 1'b0;
    #12;
    check_eq("reset_instr", a_instr, 32'h0);
    check_eq("reset_pc", a_pc, 32'h4);
    check_eq("reset_empty", 32'(a_empty), 32'd1);
    check_eq("reset_full", 32'(a_full), 32'd0);
    check_eq("reset_cnt", 32'(a_cnt), 32'd0);

    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("seq_instr_%0d", i), a_instr, 32'(i * 4));
      check_eq($sformatf("seq_pc_%0d", i), a_pc, 32'(i * 4 + 4));
    end

    // Push once, then assert reset mid-cycle
    a_call = 1'b1;
    tick();
    a_idle();
    check_eq("pre_rst_instr", a_instr, 32'h10);
    check_eq("pre_rst_cnt", 32'(a_cnt), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_eq("async_rst_instr", a_instr, 32'h0);
    check_eq("async_rst_cnt", 32'(a_cnt), 32'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Flush beats stall and prediction; aligned; RAS untouched
    a_flush = 1'b1; a_jmp = 32'h1003; a_stall = 1'b1; a_src = 1'b1;
    a_pred = 32'h555; a_call = 1'b1;
    tick();
    a_idle();
    check_eq("flush_instr", a_instr, 32'h1000);
    check_eq("flush_ras_cnt", 32'(a_cnt), 32'd0);

    // Call with prediction, then return
    a_flush_to(32'h100);
    check_eq("goto_100", a_instr, 32'h100);
    a_call = 1'b1; a_src = 1'b1; a_pred = 32'h400;
    tick();
    a_idle();
    check_eq("call_instr", a_instr, 32'h400);
    check_eq("call_cnt", 32'(a_cnt), 32'd1);
    tick();
    tick();
    check_eq("idle_after_call", a_instr, 32'h408);
    a_ret = 1'b1;
    tick();
    a_idle();
    check_eq("ret_instr", a_instr, 32'h104);
    check_eq("ret_empty", 32'(a_empty), 32'd1);
    a_ret = 1'b1;
    tick();
    a_idle();
    check_eq("ret_empty_fallthru", a_instr, 32'h108);

    // Overflow a 4-deep RAS with five calls
    a_flush_to(32'h0);
    for (int i = 0; i < 5; i++) begin
      a_call = 1'b1; a_src = 1'b1; a_pred = 32'((i + 1) * 16);
      tick();
      check_eq($sformatf("ovf_call_instr_%0d", i), a_instr, 32'((i + 1) * 16));
      check_eq($sformatf("ovf_call_cnt_%0d", i), 32'(a_cnt), 32'((i < 3) ? i + 1 : 4));
    end
    a_idle();
    check_eq("ovf_full", 32'(a_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      a_ret = 1'b1;
      tick();
      check_eq($sformatf("ovf_ret_instr_%0d", k), a_instr, 32'h44 - 32'(k * 16));
      check_eq($sformatf("ovf_ret_cnt_%0d", k), 32'(a_cnt), 32'(3 - k));
    end
    tick();
    a_idle();
    check_eq("fifth_ret_seq", a_instr, 32'h18);
    check_eq("fifth_ret_empty", 32'(a_empty), 32'd1);

    // Call+Ret replaces the top entry in place
    a_flush_to(32'h1FC);
    a_call = 1'b1; a_src = 1'b1; a_pred = 32'h50;
    tick();
    a_idle();
    check_eq("cr_setup_instr", a_instr, 32'h50);
    a_call = 1'b1; a_ret = 1'b1;
    tick();
    a_idle();
    check_eq("cr_instr", a_instr, 32'h200);
    check_eq("cr_cnt", 32'(a_cnt), 32'd1);
    a_ret = 1'b1;
    tick();
    a_idle();
    check_eq("cr_replaced_top", a_instr, 32'h54);
    check_eq("cr_pop_cnt", 32'(a_cnt), 32'd0);

    // Ret under stall: no pop, address held; misaligned prediction
    a_call = 1'b1; a_src = 1'b1; a_pred = 32'h302;
    tick();
    a_idle();
    check_eq("pred_aligned", a_instr, 32'h300);
    a_ret = 1'b1; a_stall = 1'b1;
    tick();
    a_idle();
    check_eq("stall_ret_instr", a_instr, 32'h300);
    check_eq("stall_ret_cnt", 32'(a_cnt), 32'd1);
    a_ret = 1'b1;
    tick();
    a_idle();
    check_eq("post_stall_ret", a_instr, 32'h58);

    // 32-bit wrap
    a_flush_to(32'hFFFF_FFFF);
    check_eq("a_top_addr", a_instr, 32'hFFFF_FFFC);
    check_eq("a_top_pc_wrap", a_pc, 32'h0);
    tick();
    check_eq("a_wrap_instr", a_instr, 32'h0);

    // Instance B: 16-bit wrap with 2-byte instructions, then RasClear
    b_flush = 1'b1; b_jmp = 16'hFFFF;
    tick();
    b_idle();
    check_eq("b_top_addr", 32'(b_instr), 32'hFFFE);
    check_eq("b_top_pc_wrap", 32'(b_pc), 32'h0);
    tick();
    check_eq("b_wrap_instr", 32'(b_instr), 32'h0);
    b_call = 1'b1;
    tick();
    tick();
    check_eq("b_call2_cnt", 32'(b_cnt), 32'd2);
    check_eq("b_call2_instr", 32'(b_instr), 32'h4);
    b_clr = 1'b1;
    tick();
    b_idle();
    check_eq("b_clear_cnt", 32'(b_cnt), 32'd0);
    check_eq("b_clear_empty", 32'(b_empty), 32'd1);
    check_eq("b_clear_instr", 32'(b_instr), 32'h6);
    b_ret = 1'b1;
    tick();
    b_idle();
    check_eq("b_ret_after_clear", 32'(b_instr), 32'h8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
